aes_key_expand_seq: RTL and testbench
=====================================

// Module: aes_key_expand_seq
// PURPOSE
//  Iterative AES key expansion (FIPS-197 5.2), one 32-bit schedule word per clock.
//  Sits directly upstream of the Cipher round datapath and feeds it round keys 0..NR.
//  Keys are delivered in order on a valid/ready stream, 128 bits per round key.
//  Supports AES-128/192/256 through NK/NR.
// PARAMETERS
//  NK  4   key length in 32-bit words (4, 6 or 8)
//  NR  10  number of rounds (10, 12 or 14; must match NK)
// PORTS
//  clk       in   1      single clock, rising edge
//  rst_n     in   1      asynchronous, active-low reset
//  start     in   1      begin an expansion; sampled only in IDLE
//  key       in   32*NK  cipher key; bits [32*NK-1 -: 32] = w[0]
//  busy      out  1      high from accepted start until done
//  rk_valid  out  1      rk_data/rk_round hold a round key
//  rk_ready  in   1      consumer accepts the key when rk_valid && rk_ready
//  rk_data   out  128    round key; w[4r] in bits [127:96]
//  rk_round  out  4      round index r (0..NR) of rk_data
//  done      out  1      one-cycle pulse after round key NR is accepted
// BEHAVIOUR
//  Reset: every flop clears; busy=0, rk_valid=0, rk_data=0, rk_round=0, done=0; FSM=IDLE.
//  FSM: IDLE -(start)-> RUN -(key NR accepted)-> IDLE, with done=1 for that single cycle.
//  Start edge T in IDLE: key registered, word counter i=0, rcon=0x01, busy=1 from T.
//  start while busy is ignored and does not restart or corrupt the expansion.
//  RUN: one word w[i] per advancing cycle, i = 0..4*(NR+1)-1 (43, 51 or 59 max).
//   - i < NK: w[i] = key word i.
//   - else temp = w[i-1]; if i mod NK == 0:  temp = SubWord(RotWord(temp)) ^ {rcon,24'h0},
//     then rcon <= xtime(rcon) (0x80 -> 0x1b).
//   - else if NK == 8 and i mod NK == 4: temp = SubWord(temp).
//   - w[i] = w[i-NK] ^ temp.
//  A modulo-NK counter replaces division. An NK-word shift window holds w[i-NK..i-1].
//  Words are assembled in groups of 4. The 4th word of group r loads rk_data and sets
//  rk_valid, with rk_round = r, on the same edge.
//  Timing with rk_ready held 1: key r is valid after edge T+4(r+1). Last key is valid
//  after edge T+4(NR+1). done=1 the cycle after its handshake, and busy drops on that edge.
//  Backpressure: a group-completing word stalls (i, window and rcon hold) while
//  rk_valid && !rk_ready. Non-completing words keep advancing.
//  Same-cycle handshake and reload: the old key leaves and the new key loads; no bubble.
//  rk_valid falls on handshake unless reloaded. rk_data/rk_round are stable while valid && !ready.
//  rst_n low mid-run: immediate abort to the reset state; no done and no partial key.
// STRUCTURE
//  Package aes_pkg: NK/NR legal pairs, Nb=4, SBOX table function, xtime function, state enum.
//  Sub-module aes_sub_word: 4 parallel S-box lookups, 32-bit combinational.
//  Shared with the Cipher SubBytes path.
// TESTING
//  1 NK=4/NR=10, key 2b7e151628aed2a6abf7158809cf4f3c, ready=1:
//    r0=key, r1=a0fafe1788542cb123a339392a6c7605, r10=d014f9a8c9ee2589e13f0cc8b6630ca6 at T+44.
//  2 NK=6/NR=12, key 000102..1617: r0=000102..0f,
//    r12=a4970a331a78dc09c418c271e3a41d5d, done after 13 handshakes.
//  3 NK=8/NR=14, key 000102..1e1f: r1=101112..1f, r14=24fc79ccbf0979e9371ac23c6d68de36.
//  4 Case 1 with random rk_ready stalls (incl. 20-cycle hold): same 11 keys in order,
//    rk_data stable while stalled.
//  5 start pulsed at r5 during case 1: ignored, identical key sequence, exactly one done pulse.
//  6 rst_n low after r3: outputs 0 immediately; a new start then yields the full case-1 sequence.

Source files
------------

// File: rtl/aes_key_expand_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : aes_key_expand_seq_pkg
//  Brief   : Shared AES constants, FSM state type, S-box and xtime helpers
//  Revision: 1.0  initial release
// ============================================================================
package aes_key_expand_seq_pkg;

    // Columns per state/round key
    localparam int c_NB = 4;

    // Controller states
    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    // Forward S-box, entry 0x00 in the most significant byte
    localparam logic [2047:0] c_SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Legal AES pairing: NR = NK + 6 (4/10, 6/12, 8/14)
    function automatic int nr_for_nk(input int nk);
        return nk + 6;
    endfunction

    // Single-byte S-box lookup; ~b selects the byte counted from the top
    function automatic logic [7:0] sbox(input logic [7:0] b);
        return c_SBOX[{~b, 3'b000} +: 8];
    endfunction

    // Multiply by x in GF(2^8)
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage
`default_nettype wire

// File: rtl/aes_key_expand_seq_if.sv
`default_nettype none
// ============================================================================
//  Module  : aes_key_expand_seq_if
//  Brief   : Start/key command and round-key valid/ready stream bundle
//  Revision: 1.0  initial release
// ============================================================================
interface aes_key_expand_seq_if #(
    parameter int NK = 4
);
    logic              start;
    logic [32*NK-1:0]  key;
    logic              busy;
    logic              rk_valid;
    logic              rk_ready;
    logic [127:0]      rk_data;
    logic [3:0]        rk_round;
    logic              done;

    // Requester / key consumer side
    modport master (
        output start, key, rk_ready,
        input  busy, rk_valid, rk_data, rk_round, done
    );

    // Key expansion engine side
    modport slave (
        input  start, key, rk_ready,
        output busy, rk_valid, rk_data, rk_round, done
    );
endinterface
`default_nettype wire

// File: rtl/aes_key_expand_seq_sub_word.sv
`default_nettype none
// ============================================================================
//  Module  : aes_sub_word
//  Brief   : SubWord - four parallel S-box lookups on a 32-bit word
//  Revision: 1.0  initial release
// ============================================================================
module aes_sub_word
    import aes_key_expand_seq_pkg::*;
(
    input  logic [31:0] i_word,
    output logic [31:0] o_word
);

    generate
        for (genvar b = 0; b < 4; b++) begin : g_byte
            assign o_word[8*b +: 8] = sbox(i_word[8*b +: 8]);
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/aes_key_expand_seq.sv
`default_nettype none
// ============================================================================
//  Module  : aes_key_expand_seq
//  Brief   : Iterative AES key expansion, one schedule word per clock,
//            round keys 0..NR delivered in order on a valid/ready stream
//  Revision: 1.0  initial release
// ============================================================================
module aes_key_expand_seq
    import aes_key_expand_seq_pkg::*;
#(
    parameter int NK = 4,
    parameter int NR = 10
)(
    input  logic                 clk,
    input  logic                 rst_n,
    aes_key_expand_seq_if.slave  bus
);

    localparam logic [5:0] c_WORDS    = 6'(c_NB * (NR + 1));
    localparam logic [5:0] c_NK       = 6'(NK);
    localparam logic [2:0] c_MOD_MAX  = 3'(NK - 1);
    localparam logic [3:0] c_LAST_RND = 4'(NR);

    state_t        r_state;
    logic [5:0]    r_idx;              // schedule word index i
    logic [2:0]    r_mod;              // i mod NK
    logic [7:0]    r_rcon;
    logic [31:0]   r_win [NK];         // w[i-NK] at [0] .. w[i-1] at [NK-1]
    logic [31:0]   r_grp [3];          // first three words of the current round key
    logic          r_busy;
    logic          r_valid;
    logic [127:0]  r_data;
    logic [3:0]    r_round;
    logic          r_done;

    logic [31:0]   w_prev;
    logic          w_past_key;
    logic          w_rot_sel;
    logic [31:0]   w_sub_in;
    logic [31:0]   w_sub_out;
    logic [31:0]   w_temp;
    logic [31:0]   w_word;
    logic          w_gen;
    logic          w_grp_end;
    logic          w_adv;
    logic          w_hs;
    logic          w_final_hs;

    assign w_prev     = r_win[NK-1];
    assign w_past_key = (r_idx >= c_NK);
    assign w_rot_sel  = w_past_key && (r_mod == 3'd0);
    // One S-box bank serves both the RotWord and the NK=8 mid-key cases
    assign w_sub_in   = w_rot_sel ? {w_prev[23:0], w_prev[31:24]} : w_prev;

    aes_sub_word u_sub_word (
        .i_word (w_sub_in),
        .o_word (w_sub_out)
    );

    // Select the transformed previous word that gets folded into w[i-NK]
    always_comb begin
        w_temp = w_prev;
        if (w_rot_sel) begin
            w_temp = w_sub_out ^ {r_rcon, 24'h000000};
        end else if ((NK == 8) && (r_mod == 3'd4)) begin
            w_temp = w_sub_out;
        end
    end

    // While i < NK the window is rotated so the key words come out in order
    assign w_word     = w_past_key ? (r_win[0] ^ w_temp) : r_win[0];
    assign w_gen      = (r_state == S_RUN) && (r_idx < c_WORDS);
    assign w_grp_end  = (r_idx[1:0] == 2'd3);
    // Only a group-completing word waits for the output slot to free up
    assign w_adv      = w_gen && !(w_grp_end && r_valid && !bus.rk_ready);
    assign w_hs       = r_valid && bus.rk_ready;
    assign w_final_hs = w_hs && (r_round == c_LAST_RND);

    // Controller, schedule datapath and registered stream outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_mod   <= '0;
            r_rcon  <= '0;
            for (int j = 0; j < NK; j++) r_win[j] <= '0;
            for (int j = 0; j < 3; j++)  r_grp[j] <= '0;
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
            r_data  <= '0;
            r_round <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_state <= S_RUN;
                        r_busy  <= 1'b1;
                        r_idx   <= '0;
                        r_mod   <= '0;
                        r_rcon  <= 8'h01;
                        for (int j = 0; j < NK; j++) begin
                            r_win[j] <= bus.key[32*(NK-j)-1 -: 32];
                        end
                    end
                end
                S_RUN: begin
                    if (w_adv) begin
                        r_idx <= r_idx + 6'd1;
                        r_mod <= (r_mod == c_MOD_MAX) ? 3'd0 : r_mod + 3'd1;
                        if (w_rot_sel) r_rcon <= xtime(r_rcon);
                        for (int j = 0; j < NK - 1; j++) r_win[j] <= r_win[j+1];
                        r_win[NK-1] <= w_word;
                        if (!w_grp_end) r_grp[r_idx[1:0]] <= w_word;
                    end
                    if (w_adv && w_grp_end) begin
                        r_valid <= 1'b1;
                        r_data  <= {r_grp[0], r_grp[1], r_grp[2], w_word};
                        r_round <= r_idx[5:2];
                    end else if (w_hs) begin
                        r_valid <= 1'b0;
                    end
                    if (w_final_hs) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy     = r_busy;
    assign bus.rk_valid = r_valid;
    assign bus.rk_data  = r_data;
    assign bus.rk_round = r_round;
    assign bus.done     = r_done;

endmodule
`default_nettype wire

// File: tb/tb_aes_key_expand_seq.sv
`default_nettype none
// ============================================================================
//  Module  : tb_aes_key_expand_seq
//  Brief   : Self-checking bench for AES-128/192/256 key expansion
//  Revision: 1.0  initial release
// ============================================================================
module tb_aes_key_expand_seq;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    aes_key_expand_seq_if #(.NK(4)) b4 ();
    aes_key_expand_seq_if #(.NK(6)) b6 ();
    aes_key_expand_seq_if #(.NK(8)) b8 ();

    aes_key_expand_seq #(.NK(4), .NR(10)) dut4 (.clk(clk), .rst_n(rst_n), .bus(b4.slave));
    aes_key_expand_seq #(.NK(6), .NR(12)) dut6 (.clk(clk), .rst_n(rst_n), .bus(b6.slave));
    aes_key_expand_seq #(.NK(8), .NR(14)) dut8 (.clk(clk), .rst_n(rst_n), .bus(b8.slave));

    typedef struct {
        int           rnd;
        logic [127:0] data;
        bit           chk;
    } exp_t;

    exp_t q4[$];
    exp_t q6[$];
    exp_t q8[$];

    int n_assert = 0;
    int n_fail   = 0;
    int hs4      = 0;
    int done4    = 0;
    int done6    = 0;
    int done8    = 0;

    localparam logic [127:0] c_KEY128 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [191:0] c_KEY192 = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
    localparam logic [255:0] c_KEY256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

    logic [127:0] c1_keys [11] = '{
        128'h2b7e151628aed2a6abf7158809cf4f3c,
        128'ha0fafe1788542cb123a339392a6c7605,
        128'hf2c295f27a96b9435935807a7359f67f,
        128'h3d80477d4716fe3e1e237e446d7a883b,
        128'hef44a541a8525b7fb671253bdb0bad00,
        128'hd4d1c6f87c839d87caf2b8bc11f915bc,
        128'h6d88a37a110b3efddbf98641ca0093fd,
        128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
        128'head27321b58dbad2312bf5607f8d292f,
        128'hac7766f319fadc2128d12941575c006e,
        128'hd014f9a8c9ee2589e13f0cc8b6630ca6
    };

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic push_case1(input int last);
        for (int r = 0; r <= last; r++) q4.push_back('{rnd: r, data: c1_keys[r], chk: 1'b1});
    endtask

    // AES-128 scoreboard: each handshake pops one expectation; stalled keys must hold
    initial begin : mon4
        exp_t         e;
        logic [127:0] pd;
        logic [3:0]   pr;
        bit           stall;
        stall = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (stall && b4.rk_valid) begin
                    check("stall_data4", b4.rk_data, pd);
                    check("stall_round4", 128'(b4.rk_round), 128'(pr));
                end
                if (b4.rk_valid && b4.rk_ready) begin
                    hs4++;
                    check("key_expected4", 128'(q4.size() > 0), 128'(1));
                    if (q4.size() > 0) begin
                        e = q4.pop_front();
                        check("round4", 128'(b4.rk_round), 128'(e.rnd));
                        if (e.chk) check("data4", b4.rk_data, e.data);
                    end
                end
                if (b4.done) done4++;
                stall = b4.rk_valid && !b4.rk_ready;
                pd    = b4.rk_data;
                pr    = b4.rk_round;
            end else begin
                stall = 1'b0;
            end
        end
    end

    // AES-192 scoreboard
    initial begin : mon6
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && b6.rk_valid && b6.rk_ready) begin
                check("key_expected6", 128'(q6.size() > 0), 128'(1));
                if (q6.size() > 0) begin
                    e = q6.pop_front();
                    check("round6", 128'(b6.rk_round), 128'(e.rnd));
                    if (e.chk) check("data6", b6.rk_data, e.data);
                end
            end
            if (rst_n && b6.done) done6++;
        end
    end

    // AES-256 scoreboard
    initial begin : mon8
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && b8.rk_valid && b8.rk_ready) begin
                check("key_expected8", 128'(q8.size() > 0), 128'(1));
                if (q8.size() > 0) begin
                    e = q8.pop_front();
                    check("round8", 128'(b8.rk_round), 128'(e.rnd));
                    if (e.chk) check("data8", b8.rk_data, e.data);
                end
            end
            if (rst_n && b8.done) done8++;
        end
    end

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        int h0;
        b4.start = 1'b0; b4.key = '0; b4.rk_ready = 1'b1;
        b6.start = 1'b0; b6.key = '0; b6.rk_ready = 1'b1;
        b8.start = 1'b0; b8.key = '0; b8.rk_ready = 1'b1;

        // Reset state
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 128'(b4.busy), 128'(0));
        check("rst_valid", 128'(b4.rk_valid), 128'(0));
        check("rst_data", b4.rk_data, 128'(0));
        check("rst_round", 128'(b4.rk_round), 128'(0));
        check("rst_done", 128'(b4.done), 128'(0));
        check("rst_busy8", 128'(b8.busy), 128'(0));
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Case 1: AES-128, ready held high, exact timing
        push_case1(10);
        b4.key = c_KEY128; b4.start = 1'b1;
        @(posedge clk);                                    // edge T
        #1 b4.start = 1'b0;
        check("c1_busy_T", 128'(b4.busy), 128'(1));
        check("c1_valid_T", 128'(b4.rk_valid), 128'(0));
        repeat (3) @(posedge clk); #1;                     // T+3
        check("c1_valid_T3", 128'(b4.rk_valid), 128'(0));
        @(posedge clk); #1;                                // T+4
        check("c1_valid_T4", 128'(b4.rk_valid), 128'(1));
        check("c1_round_T4", 128'(b4.rk_round), 128'(0));
        repeat (39) @(posedge clk); #1;                    // T+43
        check("c1_valid_T43", 128'(b4.rk_valid), 128'(0));
        @(posedge clk); #1;                                // T+44
        check("c1_valid_T44", 128'(b4.rk_valid), 128'(1));
        check("c1_round_T44", 128'(b4.rk_round), 128'(10));
        check("c1_data_T44", b4.rk_data, c1_keys[10]);
        check("c1_busy_T44", 128'(b4.busy), 128'(1));
        @(posedge clk); #1;                                // T+45
        check("c1_done_T45", 128'(b4.done), 128'(1));
        check("c1_busy_T45", 128'(b4.busy), 128'(0));
        check("c1_valid_T45", 128'(b4.rk_valid), 128'(0));
        @(posedge clk); #1;                                // T+46
        check("c1_done_T46", 128'(b4.done), 128'(0));
        check("c1_done_count", 128'(done4), 128'(1));
        check("c1_all_keys", 128'(q4.size()), 128'(0));

        // Case 2: AES-192
        for (int r = 0; r <= 12; r++) begin
            q6.push_back('{rnd: r,
                           data: (r == 0) ? 128'h000102030405060708090a0b0c0d0e0f
                                          : 128'ha4970a331a78dc09c418c271e3a41d5d,
                           chk: (r == 0) || (r == 12)});
        end
        d0 = done6;
        b6.key = c_KEY192; b6.start = 1'b1;
        @(posedge clk); #1 b6.start = 1'b0;
        for (int g = 0; g < 300 && done6 == d0; g++) begin @(posedge clk); #1; end
        repeat (3) @(posedge clk); #1;
        check("c2_done_pulses", 128'(done6 - d0), 128'(1));
        check("c2_all_keys", 128'(q6.size()), 128'(0));
        check("c2_idle", 128'(b6.busy), 128'(0));

        // Case 3: AES-256
        for (int r = 0; r <= 14; r++) begin
            q8.push_back('{rnd: r,
                           data: (r == 0) ? 128'h000102030405060708090a0b0c0d0e0f :
                                 (r == 1) ? 128'h101112131415161718191a1b1c1d1e1f :
                                            128'h24fc79ccbf0979e9371ac23c6d68de36,
                           chk: (r <= 1) || (r == 14)});
        end
        d0 = done8;
        b8.key = c_KEY256; b8.start = 1'b1;
        @(posedge clk); #1 b8.start = 1'b0;
        for (int g = 0; g < 300 && done8 == d0; g++) begin @(posedge clk); #1; end
        repeat (3) @(posedge clk); #1;
        check("c3_done_pulses", 128'(done8 - d0), 128'(1));
        check("c3_all_keys", 128'(q8.size()), 128'(0));

        // Case 4: random backpressure including a 20-cycle hold
        push_case1(10);
        d0 = done4;
        b4.key = c_KEY128; b4.start = 1'b1;
        @(posedge clk); #1 b4.start = 1'b0;
        for (int g = 0; g < 2000 && done4 == d0; g++) begin
            if (g >= 20 && g < 40) b4.rk_ready = 1'b0;
            else                   b4.rk_ready = ($urandom_range(0, 2) != 0);
            @(posedge clk); #1;
        end
        b4.rk_ready = 1'b1;
        repeat (3) @(posedge clk); #1;
        check("c4_done_pulses", 128'(done4 - d0), 128'(1));
        check("c4_all_keys", 128'(q4.size()), 128'(0));

        // Case 5: start (with a different key) while busy is ignored
        push_case1(10);
        d0 = done4;
        b4.key = c_KEY128; b4.start = 1'b1;
        @(posedge clk); #1 b4.start = 1'b0;
        for (int g = 0; g < 100 && !(b4.rk_valid && b4.rk_round == 4'd5); g++) begin
            @(posedge clk); #1;
        end
        b4.key = '1; b4.start = 1'b1;
        repeat (3) @(posedge clk); #1;
        b4.start = 1'b0;
        check("c5_busy_after_start", 128'(b4.busy), 128'(1));
        for (int g = 0; g < 300 && done4 == d0; g++) begin @(posedge clk); #1; end
        repeat (10) @(posedge clk); #1;
        check("c5_done_pulses", 128'(done4 - d0), 128'(1));
        check("c5_all_keys", 128'(q4.size()), 128'(0));
        check("c5_idle", 128'(b4.busy), 128'(0));

        // Case 6: reset after round key 3, then a clean full run
        push_case1(3);
        d0 = done4;
        h0 = hs4;
        b4.key = c_KEY128; b4.start = 1'b1;
        @(posedge clk); #1 b4.start = 1'b0;
        for (int g = 0; g < 200 && hs4 < h0 + 4; g++) begin @(negedge clk); #1; end
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("c6_rst_busy", 128'(b4.busy), 128'(0));
        check("c6_rst_valid", 128'(b4.rk_valid), 128'(0));
        check("c6_rst_data", b4.rk_data, 128'(0));
        check("c6_rst_round", 128'(b4.rk_round), 128'(0));
        check("c6_rst_done", 128'(b4.done), 128'(0));
        check("c6_keys_before_rst", 128'(q4.size()), 128'(0));
        repeat (2) @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("c6_no_done_on_abort", 128'(done4 - d0), 128'(0));
        push_case1(10);
        b4.start = 1'b1;
        @(posedge clk); #1 b4.start = 1'b0;
        for (int g = 0; g < 300 && done4 == d0; g++) begin @(posedge clk); #1; end
        repeat (3) @(posedge clk); #1;
        check("c6_done_pulses", 128'(done4 - d0), 128'(1));
        check("c6_all_keys", 128'(q4.size()), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
